umem_arbiter: RTL and testbench

- Arbitrates the instruction-fetch port (IF) and the data port (MEM stage) of the rv32i pipeline onto one shared single-port unified memory.
- Registers the winning request, holds it stable on the memory bus until the memory acknowledges, then returns per-requester active-low acks.
- The pipeline's existing interlock unit consumes these acks exactly as it consumes the separate memory acks today.
- Data accesses have priority because MEM holds the older instruction.

---
 rtl/umem_arbiter_if.sv | 36 +++
 rtl/umem_arbiter.sv | 92 +++++++++
 tb/tb_umem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/umem_arbiter_if.sv
// Bus bundle for the unified-memory arbiter: the fetch port, the data port
// and the shared memory port. The master modport is the arbiter's view; the
// slave modport is the view of the pipeline plus the memory around it.
interface umem_arbiter_if;
  // fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack_n;
  // data port
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack_n;
  // shared memory port
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack_n;

  modport master (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
    output i_rdata, i_ack_n, d_rdata, d_ack_n, m_req, m_write, m_size, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack_n,
    input  i_rdata, i_ack_n, d_rdata, d_ack_n, m_req, m_write, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/umem_arbiter.sv
// umem_arbiter: merges the rv32i fetch port and data port onto one
// single-port unified memory. The winning request is registered and held on
// the memory bus until m_ack_n, then a one-cycle active-low ack is returned to
// the owner. Data wins ties because MEM holds the older instruction.
// Optional feature macro UMEM_ARB_FAIR_EN: after MAX_D_STREAK consecutive data
// grants taken while a fetch waits, the fetch is granted next.
module umem_arbiter #(
  parameter logic [1:0] I_SIZE       = 2'b10,
  parameter int         MAX_D_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  umem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state;
  logic   done;     // current grant completes this cycle
  logic   arb;      // an arbitration decision is taken at the next edge
  logic   starve;   // fetch must win the next arbitration
  logic   pick_d;
  logic   pick_i;

  // Completion only counts while a grant is outstanding; acks seen in IDLE
  // are spurious and dropped here.
  assign done = (state != IDLE) && !bus.m_ack_n;
  assign arb  = (state == IDLE) || done;

`ifdef UMEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  logic [SW-1:0] streak;

  assign starve = bus.i_req && (streak == SW'(MAX_D_STREAK));

  // Count data grants that overtook a waiting fetch; any fetch grant or an
  // arbitration with no fetch pending restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      streak <= '0;
    else if (arb) begin
      if (!bus.i_req || pick_i) streak <= '0;
      else if (pick_d)          streak <= streak + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign pick_d = bus.d_req && !starve;
  assign pick_i = bus.i_req && !pick_d;

  // Grant FSM with registered memory-bus outputs. Bus fields are captured only
  // at an arbitration edge, so they stay frozen for the whole grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.m_req   <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_size  <= 2'b00;
      bus.m_addr  <= 32'h0;
      bus.m_wdata <= 32'h0;
    end else if (arb) begin
      if (pick_d) begin
        state       <= GNT_D;
        bus.m_req   <= 1'b1;
        bus.m_write <= bus.d_write;
        bus.m_size  <= bus.d_size;
        bus.m_addr  <= bus.d_addr;
        bus.m_wdata <= bus.d_wdata;
      end else if (pick_i) begin
        state       <= GNT_I;
        bus.m_req   <= 1'b1;
        bus.m_write <= 1'b0;
        bus.m_size  <= I_SIZE;
        bus.m_addr  <= bus.i_addr;
        bus.m_wdata <= 32'h0;
      end else begin
        state     <= IDLE;
        bus.m_req <= 1'b0;
      end
    end
  end

  // Acks and read data pass straight through in the completion cycle so the
  // interlock sees them with the same timing as a private memory.
  assign bus.i_ack_n = !(done && (state == GNT_I));
  assign bus.d_ack_n = !(done && (state == GNT_D));
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_umem_arbiter;

  localparam logic [1:0] I_SIZE = 2'b10;
  localparam int         MAXS   = 4;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  umem_arbiter_if bus();

  umem_arbiter #(.I_SIZE(I_SIZE), .MAX_D_STREAK(MAXS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.i_ack_n, bus.d_ack_n}
        !== {1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1})
      $display("FAIL reset_values got req=%b wr=%b size=%b addr=%h wdata=%h iack=%b dack=%b want 0/0/00/0/0/1/1",
               bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.i_ack_n, bus.d_ack_n);
    else passed++;
  endtask

  task automatic test_fetch_after_reset();
    logic [31:0] rd;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0100;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_write, bus.m_size, bus.m_addr} !== {1'b1, 1'b0, I_SIZE, 32'h100})
      $display("FAIL fetch_grant got req=%b wr=%b size=%b addr=%h want 1/0/%b/00000100",
               bus.m_req, bus.m_write, bus.m_size, bus.m_addr, I_SIZE);
    else passed++;
    total++;
    if (bus.i_ack_n !== 1'b1) $display("FAIL fetch_ack_early got %b want 1", bus.i_ack_n);
    else passed++;
    @(negedge clk);
    rd = $urandom; bus.m_rdata = rd; bus.m_ack_n = 1'b0; #1;
    total++;
    if ({bus.i_ack_n, bus.d_ack_n, bus.i_rdata} !== {1'b0, 1'b1, rd})
      $display("FAIL fetch_ack got iack=%b dack=%b rdata=%h want 0/1/%h", bus.i_ack_n, bus.d_ack_n, bus.i_rdata, rd);
    else passed++;
    bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1; #1;
    total++;
    if ({bus.i_ack_n, bus.m_req} !== 2'b10)
      $display("FAIL fetch_ack_width got iack=%b mreq=%b want 1/0", bus.i_ack_n, bus.m_req);
    else passed++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_size = 2'b10;
    bus.d_addr = 32'h8000; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_write, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b1, 32'h8000, 32'hDEAD_BEEF})
      $display("FAIL simul_data_first got req=%b wr=%b addr=%h wdata=%h want 1/1/00008000/deadbeef",
               bus.m_req, bus.m_write, bus.m_addr, bus.m_wdata);
    else passed++;
    bus.m_ack_n = 1'b0; #1;
    total++;
    if ({bus.i_ack_n, bus.d_ack_n} !== 2'b10)
      $display("FAIL simul_data_ack got iack=%b dack=%b want 1/0", bus.i_ack_n, bus.d_ack_n);
    else passed++;
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1; #1;
    total++;
    if ({bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b0, I_SIZE, 32'h200, 32'h0})
      $display("FAIL simul_fetch_b2b got req=%b wr=%b size=%b addr=%h wdata=%h want 1/0/%b/00000200/0",
               bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, I_SIZE);
    else passed++;
    @(negedge clk); bus.m_ack_n = 1'b0; #1;
    total++;
    if ({bus.i_ack_n, bus.d_ack_n} !== 2'b01)
      $display("FAIL simul_fetch_ack got iack=%b dack=%b want 0/1", bus.i_ack_n, bus.d_ack_n);
    else passed++;
    bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1;
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [31:0] rd;
    a = $urandom;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b01; bus.d_addr = a; bus.d_wdata = 32'h0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if ({bus.m_req, bus.m_addr, bus.m_size, bus.m_write, bus.i_ack_n, bus.d_ack_n}
          !== {1'b1, a, 2'b01, 1'b0, 1'b1, 1'b1})
        $display("FAIL stall_hold cyc=%0d got req=%b addr=%h size=%b wr=%b iack=%b dack=%b want 1/%h/01/0/1/1",
                 c, bus.m_req, bus.m_addr, bus.m_size, bus.m_write, bus.i_ack_n, bus.d_ack_n, a);
      else passed++;
    end
    @(negedge clk);
    rd = $urandom; bus.m_rdata = rd; bus.m_ack_n = 1'b0; #1;
    total++;
    if ({bus.d_ack_n, bus.i_ack_n, bus.d_rdata} !== {1'b0, 1'b1, rd})
      $display("FAIL stall_ack got dack=%b iack=%b rdata=%h want 0/1/%h", bus.d_ack_n, bus.i_ack_n, bus.d_rdata, rd);
    else passed++;
    bus.d_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1; #1;
    total++;
    if ({bus.m_req, bus.m_addr, bus.m_size} !== {1'b1, 32'h500, I_SIZE})
      $display("FAIL stall_then_fetch got req=%b addr=%h size=%b want 1/00000500/%b",
               bus.m_req, bus.m_addr, bus.m_size, I_SIZE);
    else passed++;
    @(negedge clk); bus.m_ack_n = 1'b0;
    bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_size = 2'b00;
    bus.d_addr = 32'h9000; bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.i_ack_n, bus.d_ack_n}
        !== {1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1})
      $display("FAIL reset_mid got req=%b wr=%b size=%b addr=%h wdata=%h iack=%b dack=%b want 0/0/00/0/0/1/1",
               bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, bus.i_ack_n, bus.d_ack_n);
    else passed++;
    bus.d_req = 1'b0; bus.d_write = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_addr, bus.m_size, bus.m_write} !== {1'b1, 32'h400, I_SIZE, 1'b0})
      $display("FAIL reset_mid_fetch got req=%b addr=%h size=%b wr=%b want 1/00000400/%b/0",
               bus.m_req, bus.m_addr, bus.m_size, bus.m_write, I_SIZE);
    else passed++;
    bus.m_ack_n = 1'b0;
    bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1;
  endtask

  task automatic test_fair();
    bit fair;
    bit exp_i;
`ifdef UMEM_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h8000;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.m_ack_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      exp_i = fair && ((k % (MAXS + 1)) == MAXS);
      total++;
      if ({bus.m_req, bus.m_addr, bus.i_ack_n, bus.d_ack_n}
          !== {1'b1, (exp_i ? 32'h300 : 32'h8000), !exp_i, exp_i})
        $display("FAIL fair_seq k=%0d got req=%b addr=%h iack=%b dack=%b want 1/%h/%b/%b",
                 k, bus.m_req, bus.m_addr, bus.i_ack_n, bus.d_ack_n,
                 (exp_i ? 32'h300 : 32'h8000), !exp_i, exp_i);
      else passed++;
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1;
  endtask

  task automatic test_spurious();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.m_ack_n = 1'b0; #1;
      total++;
      if ({bus.m_req, bus.i_ack_n, bus.d_ack_n} !== 3'b011)
        $display("FAIL spurious_ack cyc=%0d got req=%b iack=%b dack=%b want 0/1/1",
                 c, bus.m_req, bus.i_ack_n, bus.d_ack_n);
      else passed++;
    end
    @(negedge clk); bus.m_ack_n = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h600;
    @(negedge clk); #1;
    total++;
    if ({bus.m_req, bus.m_addr, bus.i_ack_n} !== {1'b1, 32'h600, 1'b1})
      $display("FAIL spurious_then_fetch got req=%b addr=%h iack=%b want 1/00000600/1",
               bus.m_req, bus.m_addr, bus.i_ack_n);
    else passed++;
    bus.m_ack_n = 1'b0; bus.i_req = 1'b0;
    @(negedge clk); bus.m_ack_n = 1'b1;
  endtask

  // Transaction-level model: who owns the memory and what it must see.
  // Requesters issue a new request (or go quiet) once served; a request not
  // yet granted may be withdrawn or replaced at any time.
  task automatic test_random(input int n);
    int          owner;   // 0 none, 1 fetch, 2 data
    int          streak;
    logic        ewr;
    logic [1:0]  es;
    logic [31:0] ea, ew, rd;
    bit          ackin, blk, exp_i, exp_d;
    owner = 0; streak = 0; ewr = 0; es = 0; ea = 0; ew = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      total++;
      if (owner == 0 ? (bus.m_req !== 1'b0)
          : ({bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata} !== {1'b1, ewr, es, ea, ew}))
        $display("FAIL rand_bus cyc=%0d got req=%b wr=%b size=%b addr=%h wdata=%h want owner=%0d %b/%b/%h/%h",
                 c, bus.m_req, bus.m_write, bus.m_size, bus.m_addr, bus.m_wdata, owner, ewr, es, ea, ew);
      else passed++;
      ackin = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rd = $urandom;
      bus.m_ack_n = !ackin; bus.m_rdata = rd;
      #1;
      exp_i = !(owner == 1 && ackin);
      exp_d = !(owner == 2 && ackin);
      total++;
      if ({bus.i_ack_n, bus.d_ack_n} !== {exp_i, exp_d} ||
          (!exp_i && bus.i_rdata !== rd) || (!exp_d && bus.d_rdata !== rd))
        $display("FAIL rand_ack cyc=%0d got iack=%b dack=%b irdata=%h drdata=%h want %b/%b rdata=%h",
                 c, bus.i_ack_n, bus.d_ack_n, bus.i_rdata, bus.d_rdata, exp_i, exp_d, rd);
      else passed++;
      if (owner != 1 || ackin) begin
        bus.i_req = ($urandom_range(0, 3) != 0);
        bus.i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (owner != 2 || ackin) begin
        bus.d_req = $urandom_range(0, 1);
        bus.d_write = $urandom_range(0, 1);
        bus.d_size = 2'($urandom_range(0, 2));
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
      end
      if (owner == 0 || ackin) begin
`ifdef UMEM_ARB_FAIR_EN
        blk = bus.i_req && (streak == MAXS);
`else
        blk = 1'b0;
`endif
        if (bus.d_req && !blk) begin
          owner = 2; ewr = bus.d_write; es = bus.d_size; ea = bus.d_addr; ew = bus.d_wdata;
          streak = bus.i_req ? streak + 1 : 0;
        end else if (bus.i_req) begin
          owner = 1; ewr = 1'b0; es = I_SIZE; ea = bus.i_addr; ew = 32'h0;
          streak = 0;
        end else begin
          owner = 0; streak = 0;
        end
      end
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_size = 2'b00;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.m_rdata = 32'h0; bus.m_ack_n = 1'b1;
    test_reset();
    test_fetch_after_reset();
    test_simultaneous();
    test_stall();
    test_reset_mid();
    test_fair();
    test_spurious();
    test_random(600);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
